// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-multiply datapath: loader state encoding,
// element geometry and the last element index of a 2x2 operand.
package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 4;
  localparam int MAT_W  = 32;

  // Element index width and the index of the final element of an operand.
  localparam int              IDX_W    = 2;
  localparam logic [IDX_W-1:0] IDX_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/matrix_operand_loader.sv
// Operand sequencer in front of the matrix-multiply unit. On a start from
// decode it reads four elements of A, then four of B, one per cycle, packs
// them into the A/B buses, stalls the pipeline meanwhile and pulses valid
// once both operands are complete.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; no memory traffic, busy low
// LOAD_A | reading A element idx from base_a+idx
// LOAD_B | reading B element idx from base_b+idx
// DONE   | A and B complete; valid high for this single cycle
module matrix_operand_loader
  import matrix_pkg::state_e, matrix_pkg::IDLE, matrix_pkg::LOAD_A,
         matrix_pkg::LOAD_B, matrix_pkg::DONE, matrix_pkg::IDX_W,
         matrix_pkg::IDX_LAST;
#(
  parameter int ADDR_W = 8,
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int N_ELEM = matrix_pkg::N_ELEM
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        base_a,
  input  logic [ADDR_W-1:0]        base_b,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [ELEM_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic [N_ELEM*ELEM_W-1:0] A,
  output logic [N_ELEM*ELEM_W-1:0] B,
  output logic                     valid,
  output logic                     overrun
);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ADDR_W-1:0]          base_a_q, base_a_d;
  logic [ADDR_W-1:0]          base_b_q, base_b_d;
  logic [N_ELEM*ELEM_W-1:0]   a_q, a_d;
  logic [N_ELEM*ELEM_W-1:0]   b_q, b_d;
  logic                       overrun_q, overrun_d;

  // Next-state: sequencing, element capture and overrun tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    a_d       = a_q;
    b_d       = b_q;
    overrun_d = overrun_q;

    // A request arriving while a load is in flight is dropped but remembered.
    if (start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // flush outranks start so a squashed instruction never loads.
        if (start && !flush) begin
          base_a_d = base_a;
          base_b_d = base_b;
          idx_d    = '0;
          state_d  = LOAD_A;
        end
      end
      LOAD_A: begin
        if (flush) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          a_d[idx_q*ELEM_W +: ELEM_W] = mem_rdata;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (flush) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          b_d[idx_q*ELEM_W +: ELEM_W] = mem_rdata;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state/idx so nothing upstream
  // can ripple combinationally into the stall or memory strobe.
  always_comb begin
    busy     = 1'b0;
    valid    = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state_q)
      LOAD_A: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = base_a_q + ADDR_W'(idx_q);
      end
      LOAD_B: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = base_b_q + ADDR_W'(idx_q);
      end
      DONE: begin
        busy  = 1'b1;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      a_q       <= a_d;
      b_q       <= b_d;
      overrun_q <= overrun_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: a cycle-count reference model predicts the
// control outputs and operand buses, a scoreboard queue holds the expected
// operands of each accepted load, and one monitor process does all checking.
module tb_matrix_operand_loader;
  import matrix_pkg::*;

  logic               CLK = 1'b0;
  logic               reset;
  logic               start;
  logic               flush;
  logic [7:0]         base_a;
  logic [7:0]         base_b;
  logic               mem_rd;
  logic [7:0]         mem_addr;
  logic [ELEM_W-1:0]  mem_rdata;
  logic               busy;
  logic [MAT_W-1:0]   A;
  logic [MAT_W-1:0]   B;
  logic               valid;
  logic               overrun;

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  always #5 CLK = ~CLK;

  matrix_operand_loader #(
    .ADDR_W (8),
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .base_a    (base_a),
    .base_b    (base_b),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .A         (A),
    .B         (B),
    .valid     (valid),
    .overrun   (overrun)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } xact_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] exp;
  } probe_t;

  xact_t  exp_q[$];
  probe_t probe_q[$];
  bit     finish_req = 1'b0;
  int     n_tests = 0;
  int     n_fail  = 0;

  // Reference model: m_k counts cycles since the accepted start
  // (0 = idle, 1..4 reading A, 5..8 reading B, 9 = valid cycle).
  int          m_k   = 0;
  logic [7:0]  m_ba  = '0;
  logic [7:0]  m_bb  = '0;
  logic [31:0] m_a   = '0;
  logic [31:0] m_b   = '0;
  logic        m_ovr = 1'b0;

  function automatic logic [31:0] pack(input logic [7:0] base);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = mem[8'(base + 8'(i))];
    return r;
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_k = 0; m_ba = '0; m_bb = '0; m_a = '0; m_b = '0; m_ovr = 1'b0;
      exp_q.delete();
    end else if (m_k == 0) begin
      if (start && !flush) begin
        m_ba = base_a; m_bb = base_b; m_k = 1;
        exp_q.push_back('{a: pack(base_a), b: pack(base_b)});
      end
    end else begin
      if (start) m_ovr = 1'b1;
      if (flush) begin
        if (m_k < 9) void'(exp_q.pop_back());
        m_k = 0;
      end else begin
        if (m_k <= 4)      m_a[(m_k-1)*8 +: 8] = mem[8'(m_ba + 8'(m_k-1))];
        else if (m_k <= 8) m_b[(m_k-5)*8 +: 8] = mem[8'(m_bb + 8'(m_k-5))];
        m_k = (m_k == 9) ? 0 : m_k + 1;
      end
    end
  end

  function automatic logic [31:0] probe_val(input logic [3:0] s);
    case (s)
      4'd0:    return A;
      4'd1:    return B;
      4'd2:    return {31'b0, busy};
      4'd3:    return {31'b0, valid};
      4'd4:    return {31'b0, mem_rd};
      4'd5:    return {24'b0, mem_addr};
      4'd6:    return {31'b0, overrun};
      default: return {8'b0, B[31:8]};
    endcase
  endfunction

  function automatic string probe_name(input logic [3:0] s);
    case (s)
      4'd0:    return "A";
      4'd1:    return "B";
      4'd2:    return "busy";
      4'd3:    return "valid";
      4'd4:    return "mem_rd";
      4'd5:    return "mem_addr";
      4'd6:    return "overrun";
      default: return "B_hi";
    endcase
  endfunction

  // Monitor: every comparison of the bench happens here, on the falling edge.
  always @(negedge CLK) begin
    logic       e_busy, e_valid, e_rd;
    logic [7:0] e_addr;
    xact_t      x;
    probe_t     p;
    logic [31:0] act;

    e_busy  = (m_k != 0);
    e_valid = (m_k == 9);
    e_rd    = (m_k >= 1) && (m_k <= 8);
    e_addr  = '0;
    if (m_k >= 1 && m_k <= 4)      e_addr = 8'(m_ba + 8'(m_k-1));
    else if (m_k >= 5 && m_k <= 8) e_addr = 8'(m_bb + 8'(m_k-5));

    n_tests++;
    if ({busy, valid, mem_rd, mem_addr, overrun} !== {e_busy, e_valid, e_rd, e_addr, m_ovr}) begin
      n_fail++;
      $display("FAIL ctl @%0t: busy/valid/rd/addr/ovr = %b/%b/%b/%02h/%b, required %b/%b/%b/%02h/%b",
               $time, busy, valid, mem_rd, mem_addr, overrun, e_busy, e_valid, e_rd, e_addr, m_ovr);
    end

    n_tests++;
    if (A !== m_a || B !== m_b) begin
      n_fail++;
      $display("FAIL operands @%0t: A=%08h B=%08h, required A=%08h B=%08h", $time, A, B, m_a, m_b);
    end

    if (valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_valid @%0t: valid=1 with no load outstanding, required none", $time);
      end else begin
        x = exp_q.pop_front();
        if (A !== x.a || B !== x.b) begin
          n_fail++;
          $display("FAIL sb_result @%0t: A=%08h B=%08h, required A=%08h B=%08h", $time, A, B, x.a, x.b);
        end
      end
    end

    while (probe_q.size() > 0) begin
      p   = probe_q.pop_front();
      act = probe_val(p.sel);
      n_tests++;
      if (act !== p.exp) begin
        n_fail++;
        $display("FAIL probe_%s @%0t: got %08h, required %08h", probe_name(p.sel), $time, act, p.exp);
      end
    end

    if (finish_req) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL sb_leftover: %0d loads never produced valid, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic probe(input logic [3:0] sel, input logic [31:0] exp);
    probe_q.push_back('{sel: sel, exp: exp});
  endtask

  // Presents start for one cycle; returns in cycle 1 of the load.
  task automatic launch(input logic [7:0] ba, input logic [7:0] bb);
    start  = 1'b1;
    base_a = ba;
    base_b = bb;
    tick();
    start  = 1'b0;
    base_a = 8'($urandom);
    base_b = 8'($urandom);
  endtask

  initial begin
    logic [31:0] exp_a, exp_b, prev_b;
    logic [7:0]  ba, bb;
    int          mode, c;

    reset = 1'b0; start = 1'b0; flush = 1'b0; base_a = '0; base_b = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = 8'(i + 1);
      mem[8'h20 + i] = 8'(i + 5);
    end

    repeat (2) tick();
    probe(0, 32'h0); probe(1, 32'h0); probe(2, 32'h0); probe(6, 32'h0);
    reset = 1'b1;
    tick();

    // Basic load
    launch(8'h10, 8'h20);
    probe(2, 32'h1);
    repeat (8) tick();
    probe(3, 32'h1); probe(0, 32'h04030201); probe(1, 32'h08070605); probe(2, 32'h1);
    tick();
    probe(2, 32'h0); probe(3, 32'h0);

    // Address wrap past 0xFF
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    launch(8'hFE, 8'h20);
    probe(5, 32'hFE); tick();
    probe(5, 32'hFF); tick();
    probe(5, 32'h00); tick();
    probe(5, 32'h01);
    repeat (5) tick();
    probe(0, 32'hDDCCBBAA);
    tick();

    // Start while busy, then back-to-back at the earliest legal cycle
    launch(8'h10, 8'h20);
    repeat (3) tick();
    start = 1'b1; base_a = 8'h55;
    tick();
    start = 1'b0;
    probe(6, 32'h1);
    repeat (5) tick();
    launch(8'h20, 8'h10);
    repeat (8) tick();
    probe(3, 32'h1); probe(0, 32'h08070605); probe(1, 32'h04030201); probe(6, 32'h1);
    tick();

    // Flush during LOAD_B
    prev_b = 32'h04030201;
    exp_a  = pack(8'h30);
    launch(8'h30, 8'h40);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    probe(2, 32'h0); probe(0, exp_a);
    probe(1, {prev_b[31:8], mem[8'h40]}); probe(7, {8'h0, prev_b[31:8]});
    repeat (3) tick();

    // Asynchronous reset in the middle of LOAD_A
    launch(8'h10, 8'h20);
    repeat (2) tick();
    #2 reset = 1'b0;
    probe(2, 32'h0); probe(4, 32'h0); probe(5, 32'h0);
    probe(0, 32'h0); probe(1, 32'h0); probe(6, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    exp_a = pack(8'h40);
    exp_b = pack(8'h30);
    launch(8'h40, 8'h30);
    repeat (8) tick();
    probe(3, 32'h1); probe(0, exp_a); probe(1, exp_b);
    tick();

    // start and flush together while idle
    start = 1'b1; flush = 1'b1; base_a = 8'h10; base_b = 8'h20;
    tick();
    start = 1'b0; flush = 1'b0;
    probe(2, 32'h0); probe(4, 32'h0);
    tick();
    probe(2, 32'h0);

    // Randomized loads with occasional overlapping starts and flushes
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      for (int j = 0; j < 8; j++) mem[8'($urandom)] = 8'($urandom);
      ba = 8'($urandom);
      bb = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      c    = int'($urandom_range(1, 9));
      launch(ba, bb);
      if (mode == 0) begin
        repeat (9) tick();
      end else if (mode == 1) begin
        repeat (c - 1) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9 - c) tick();
      end else begin
        repeat (c - 1) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end

    repeat (3) tick();
    finish_req = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
